if_id_stage: RTL and testbench

- IF/ID pipeline register for the single-issue MIPS-style core. It sits between instruction fetch and decode, and its decoded fields feed control, the register file and the ID_EX register.
- Includes load-use hazard detection. On a hazard it stalls the PC and IF/ID, and it requests a control bubble into ID_EX.
- A jump taken in EX flushes it.
- Holds 32-bit stall and flush performance counters.

---
 rtl/if_id_stage.sv | 94 +++++++++
 tb/tb_if_id_stage.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use hazard detection, jump flush and
// saturating stall/flush performance counters.
module if_id_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [31:0]      Instruction,
    input  logic [31:0]      PCAddress,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_rt,
    input  logic             Flush,
    output logic [31:0]      InstructionOut,
    output logic [31:0]      PCAddressOut,
    output logic             ValidOut,
    output logic             PCWrite,
    output logic             Bubble,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    typedef enum logic [1:0] {
        MODE_RUN   = 2'd0,
        MODE_STALL = 2'd1,
        MODE_FLUSH = 2'd2
    } mode_t;

    mode_t      mode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       hazard;

    assign rs = InstructionOut[25:21];
    assign rt = InstructionOut[20:16];

    // Both source fields are compared regardless of format; a false stall is harmless.
    assign hazard = ValidOut & ID_EX_MemRead & (ID_EX_rt != 5'd0) &
                    ((ID_EX_rt == rs) | (ID_EX_rt == rt));

    always_comb begin
        mode    = MODE_RUN;
        PCWrite = 1'b1;
        Bubble  = 1'b0;
        if (Flush) begin
            mode   = MODE_FLUSH;
            Bubble = 1'b1;
        end else if (hazard) begin
            mode    = MODE_STALL;
            PCWrite = 1'b0;
            Bubble  = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            InstructionOut <= NOP_INSTR;
            PCAddressOut   <= '0;
            ValidOut       <= 1'b0;
        end else begin
            unique case (mode)
                MODE_FLUSH: begin
                    InstructionOut <= NOP_INSTR;
                    PCAddressOut   <= PCAddress;
                    ValidOut       <= 1'b0;
                end
                MODE_STALL: begin
                    InstructionOut <= InstructionOut;
                    PCAddressOut   <= PCAddressOut;
                    ValidOut       <= ValidOut;
                end
                default: begin
                    InstructionOut <= Instruction;
                    PCAddressOut   <= PCAddress;
                    ValidOut       <= 1'b1;
                end
            endcase
        end
    end

    // Counters stick at all-ones instead of wrapping.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (mode == MODE_STALL && StallCount != '1)
                StallCount <= StallCount + CNT_W'(1);
            if (mode == MODE_FLUSH && FlushCount != '1)
                FlushCount <= FlushCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Randomized bench for if_id_stage: a behavioural model of the IF/ID register
// is checked every cycle, plus literal checks for the directed scenarios.
module tb_if_id_stage;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [31:0] Instruction;
    logic [31:0] PCAddress;
    logic        ID_EX_MemRead;
    logic [4:0]  ID_EX_rt;
    logic        Flush;

    logic [31:0] InstructionOut, PCAddressOut;
    logic        ValidOut, PCWrite, Bubble;
    logic [31:0] StallCount, FlushCount;

    logic [31:0] InstructionOut4, PCAddressOut4;
    logic        ValidOut4, PCWrite4, Bubble4;
    logic [3:0]  StallCount4, FlushCount4;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic        m_valid;
    longint      m_stalls;
    longint      m_flushes;

    always #5 Clk = ~Clk;

    if_id_stage dut (
        .Clk(Clk), .Rst_n(Rst_n), .Instruction(Instruction), .PCAddress(PCAddress),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rt(ID_EX_rt), .Flush(Flush),
        .InstructionOut(InstructionOut), .PCAddressOut(PCAddressOut), .ValidOut(ValidOut),
        .PCWrite(PCWrite), .Bubble(Bubble), .StallCount(StallCount), .FlushCount(FlushCount)
    );

    if_id_stage #(.CNT_W(4)) dut4 (
        .Clk(Clk), .Rst_n(Rst_n), .Instruction(Instruction), .PCAddress(PCAddress),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rt(ID_EX_rt), .Flush(Flush),
        .InstructionOut(InstructionOut4), .PCAddressOut(PCAddressOut4), .ValidOut(ValidOut4),
        .PCWrite(PCWrite4), .Bubble(Bubble4), .StallCount(StallCount4), .FlushCount(FlushCount4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat4(input longint n);
        return (n > 15) ? 32'd15 : 32'(n);
    endfunction

    // Compares DUT outputs with the model, then advances the model over the coming edge.
    task automatic model_check();
        logic hz;
        #2;
        if (!Rst_n) begin
            m_instr = 32'h0; m_pc = 32'h0; m_valid = 1'b0;
            m_stalls = 0; m_flushes = 0;
        end
        hz = m_valid && ID_EX_MemRead && (ID_EX_rt != 5'd0) &&
             (ID_EX_rt == m_instr[25:21] || ID_EX_rt == m_instr[20:16]);
        chk("instr", InstructionOut, m_instr);
        chk("pc", PCAddressOut, m_pc);
        chk("valid", 32'(ValidOut), 32'(m_valid));
        chk("pcwrite", 32'(PCWrite), 32'(Flush || !hz));
        chk("bubble", 32'(Bubble), 32'(Flush || hz));
        chk("stallcnt", StallCount, 32'(m_stalls));
        chk("flushcnt", FlushCount, 32'(m_flushes));
        chk("instr4", InstructionOut4, m_instr);
        chk("stallcnt4", 32'(StallCount4), sat4(m_stalls));
        chk("flushcnt4", 32'(FlushCount4), sat4(m_flushes));
        if (Rst_n) begin
            if (Flush) begin
                m_instr = 32'h0; m_pc = PCAddress; m_valid = 1'b0; m_flushes++;
            end else if (hz) begin
                m_stalls++;
            end else begin
                m_instr = Instruction; m_pc = PCAddress; m_valid = 1'b1;
            end
        end
    endtask

    task automatic drive_random();
        Instruction   = {6'($urandom), 5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)),
                         16'($urandom)};
        PCAddress     = PCAddress + 32'd4;
        ID_EX_MemRead = 1'($urandom_range(1, 0));
        ID_EX_rt      = 5'($urandom_range(3, 0));
        Flush         = ($urandom_range(9, 0) == 0);
    endtask

    initial begin
        Rst_n = 1'b0; Flush = 1'b0; ID_EX_MemRead = 1'b0; ID_EX_rt = 5'd0;
        Instruction = 32'h8C08_0004; PCAddress = 32'h4;

        // Reset then stream
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk); model_check(); #1;
            chk("rst_instr", InstructionOut, 32'h0);
            chk("rst_valid", 32'(ValidOut), 32'd0);
            chk("rst_pcwrite", 32'(PCWrite), 32'd1);
            chk("rst_bubble", 32'(Bubble), 32'd0);
        end
        @(negedge Clk); Rst_n = 1'b1; model_check();
        @(negedge Clk); Instruction = 32'h0109_4020; PCAddress = 32'h8; model_check(); #1;
        chk("t1_instr", InstructionOut, 32'h8C08_0004);
        chk("t1_valid", 32'(ValidOut), 32'd1);
        chk("t1_pcwrite", 32'(PCWrite), 32'd1);
        chk("t1_bubble", 32'(Bubble), 32'd0);

        // Load-use stall on rs=8
        @(negedge Clk); ID_EX_MemRead = 1'b1; ID_EX_rt = 5'd8; Instruction = 32'h0000_4020;
        PCAddress = 32'hC; model_check(); #1;
        chk("t2_pcwrite", 32'(PCWrite), 32'd0);
        chk("t2_bubble", 32'(Bubble), 32'd1);
        chk("t2_cnt0", StallCount, 32'd0);
        @(negedge Clk); ID_EX_MemRead = 1'b0; model_check(); #1;
        chk("t2_hold", InstructionOut, 32'h0109_4020);
        chk("t2_cnt1", StallCount, 32'd1);
        chk("t2_release", 32'(PCWrite), 32'd1);

        // $zero exclusion
        @(negedge Clk); ID_EX_MemRead = 1'b1; ID_EX_rt = 5'd0; Instruction = 32'h2010_000A;
        PCAddress = 32'h10; model_check(); #1;
        chk("t3_instr", InstructionOut, 32'h0000_4020);
        chk("t3_bubble", 32'(Bubble), 32'd0);
        chk("t3_pcwrite", 32'(PCWrite), 32'd1);

        // Flush
        @(negedge Clk); ID_EX_MemRead = 1'b0; Flush = 1'b1; model_check(); #1;
        chk("t4_bubble", 32'(Bubble), 32'd1);
        chk("t4_pcwrite", 32'(PCWrite), 32'd1);
        @(negedge Clk); Flush = 1'b0; Instruction = 32'h0109_4020; PCAddress = 32'h14;
        model_check(); #1;
        chk("t4_instr", InstructionOut, 32'h0);
        chk("t4_valid", 32'(ValidOut), 32'd0);
        chk("t4_fcnt", FlushCount, 32'd1);
        chk("t4_pc", PCAddressOut, 32'h10);

        // Flush together with hazard on rt=9
        @(negedge Clk); Flush = 1'b1; ID_EX_MemRead = 1'b1; ID_EX_rt = 5'd9;
        Instruction = 32'h2010_000A; PCAddress = 32'h18; model_check(); #1;
        chk("t5_instr_pre", InstructionOut, 32'h0109_4020);
        chk("t5_pcwrite", 32'(PCWrite), 32'd1);
        chk("t5_bubble", 32'(Bubble), 32'd1);
        @(negedge Clk); Flush = 1'b0; ID_EX_MemRead = 1'b0; model_check(); #1;
        chk("t5_instr", InstructionOut, 32'h0);
        chk("t5_fcnt", FlushCount, 32'd2);
        chk("t5_scnt", StallCount, 32'd1);

        // Randomized traffic; also drives the 4-bit counters into saturation
        for (int i = 0; i < 3000; i++) begin
            @(negedge Clk); drive_random(); model_check();
        end
        chk("t6_sat4", 32'(StallCount4), 32'hF);

        // Asynchronous reset mid-cycle
        @(negedge Clk); drive_random(); Flush = 1'b0; model_check();
        #1 Rst_n = 1'b0;
        #1;
        chk("t6_ar_instr", InstructionOut, 32'h0);
        chk("t6_ar_pc", PCAddressOut, 32'h0);
        chk("t6_ar_valid", 32'(ValidOut), 32'd0);
        chk("t6_ar_scnt", StallCount, 32'd0);
        chk("t6_ar_fcnt", FlushCount, 32'd0);
        chk("t6_ar_scnt4", 32'(StallCount4), 32'd0);
        chk("t6_ar_pcwrite", 32'(PCWrite), 32'd1);
        chk("t6_ar_bubble", 32'(Bubble), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk); model_check();
        end
        @(negedge Clk); Rst_n = 1'b1; model_check();
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk); drive_random(); model_check();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
